// File: rtl/riscv_du_pkg.sv
// Debug-unit shared definitions: address map constants, command opcodes and
// the state encodings used by the debug command sequencer.
package riscv_du_pkg;
   localparam int DU_ADDR_SIZE  = 12;
   localparam int DBG_ADDR_SIZE = 16;
   localparam int BANK_SIZE     = DBG_ADDR_SIZE - DU_ADDR_SIZE;

   localparam logic [BANK_SIZE-1:0]    DBG_INTERNAL = 4'h0;
   localparam logic [DU_ADDR_SIZE-1:0] DBG_CTRL     = 12'h000;
   localparam logic [DU_ADDR_SIZE-1:0] DBG_HIT      = 12'h001;

   typedef enum logic [2:0] {
      CMD_NOP    = 3'd0,
      CMD_HALT   = 3'd1,
      CMD_RESUME = 3'd2,
      CMD_STEP   = 3'd3,
      CMD_RD     = 3'd4,
      CMD_WR     = 3'd5
   } dbg_cmd_op_t;

   typedef enum logic [2:0] {S_IDLE, S_ACC, S_GAP, S_RUN, S_RESP} dbg_state_t;
   typedef enum logic [1:0] {PH_SINGLE, PH_SET, PH_HIT, PH_CLR} dbg_phase_t;
   typedef enum logic [1:0] {A_IDLE, A_ACC, A_GAP} acc_state_t;

   function automatic logic [BANK_SIZE-1:0] addr_bank(input logic [DBG_ADDR_SIZE-1:0] addr);
      return addr[DBG_ADDR_SIZE-1:DU_ADDR_SIZE];
   endfunction
endpackage

// File: rtl/riscv_dbg_acc.sv
// Single debug-port access engine: strobe held until ack or timeout, followed
// by one strobe-low GAP cycle. A new start is taken in IDLE or in GAP.
module riscv_dbg_acc
   import riscv_du_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     we,
   input  logic [DBG_ADDR_SIZE-1:0] addr,
   input  logic [XLEN-1:0]          data,
   output logic                     done,
   output logic                     err,
   output logic [XLEN-1:0]          rdata,
   output logic                     dbg_strb,
   output logic                     dbg_we,
   output logic [DBG_ADDR_SIZE-1:0] dbg_addr,
   output logic [XLEN-1:0]          dbg_dati,
   input  logic [XLEN-1:0]          dbg_dato,
   input  logic                     dbg_ack
);
   localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

   acc_state_t               state_reg, state_next;
   logic [CW-1:0]            cnt_reg;
   logic                     we_reg;
   logic [DBG_ADDR_SIZE-1:0] addr_reg;
   logic [XLEN-1:0]          data_reg, rdata_reg;
   logic                     expired;

   assign expired  = (cnt_reg == CW'(TIMEOUT - 1));
   assign dbg_strb = (state_reg == A_ACC);
   assign dbg_we   = we_reg;
   assign dbg_addr = addr_reg;
   assign dbg_dati = data_reg;
   assign rdata    = rdata_reg;
   assign done     = (state_reg == A_ACC) && (dbg_ack || expired);
   assign err      = done && !dbg_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= A_IDLE;
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            we_reg   <= we;
            addr_reg <= addr;
            data_reg <= data;
            cnt_reg  <= '0;
         end else if (state_reg == A_ACC) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (state_reg == A_ACC && dbg_ack && !we_reg)
            rdata_reg <= dbg_dato;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         A_IDLE:  if (start) state_next = A_ACC;
         A_ACC:   if (dbg_ack || expired) state_next = A_GAP;
         A_GAP:   state_next = start ? A_ACC : A_IDLE;
         default: state_next = A_IDLE;
      endcase
   end
endmodule

// File: rtl/riscv_dbg_ctrl.sv
// Debug command sequencer: expands halt/resume/step/read/write commands into
// ordered debug-port accesses and tracks the halted/running state.
module riscv_dbg_ctrl
   import riscv_du_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int TIMEOUT       = 1024,
   parameter bit HALT_ON_RESET = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_op,
   input  logic [DBG_ADDR_SIZE-1:0] cmd_addr,
   input  logic [XLEN-1:0]          cmd_data,
   output logic                     rsp_valid,
   output logic [XLEN-1:0]          rsp_data,
   output logic                     rsp_err,
   output logic                     halted,
   output logic                     bp_event,
   output logic                     dbg_stall,
   output logic                     dbg_strb,
   output logic                     dbg_we,
   output logic [DBG_ADDR_SIZE-1:0] dbg_addr,
   output logic [XLEN-1:0]          dbg_dati,
   input  logic [XLEN-1:0]          dbg_dato,
   input  logic                     dbg_ack,
   input  logic                     dbg_bp
);
   localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
   localparam logic [DBG_ADDR_SIZE-1:0] CTRL_ADDR = {DBG_INTERNAL, DBG_CTRL};
   localparam logic [DBG_ADDR_SIZE-1:0] HIT_ADDR  = {DBG_INTERNAL, DBG_HIT};

   dbg_state_t    state_reg, state_next;
   dbg_phase_t    phase_reg, phase_next;
   dbg_cmd_op_t   op_reg, op_next;
   logic          err_reg, err_next, fail_reg, fail_next;
   logic          stall_reg, stall_next, halted_reg, halted_next;
   logic          bp_event_reg, bp_event_next;
   logic [1:0]    shadow_reg, shadow_next, wr_data_reg, wr_data_next;
   logic          wr_ctrl_reg, wr_ctrl_next;
   logic [CW-1:0] run_cnt_reg, run_cnt_next;
   logic          halted_eff;

   logic                     acc_start, acc_we, acc_done, acc_err;
   logic [DBG_ADDR_SIZE-1:0] acc_addr;
   logic [XLEN-1:0]          acc_data, acc_rdata;

   riscv_dbg_acc #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) u_acc (
      .clk(clk), .rst(rst), .start(acc_start), .we(acc_we), .addr(acc_addr),
      .data(acc_data), .done(acc_done), .err(acc_err), .rdata(acc_rdata),
      .dbg_strb(dbg_strb), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_dati(dbg_dati), .dbg_dato(dbg_dato), .dbg_ack(dbg_ack)
   );

   assign cmd_ready = (state_reg == S_IDLE);
   assign rsp_valid = (state_reg == S_RESP);
   assign rsp_err   = rsp_valid && err_reg;
   assign rsp_data  = (rsp_valid && op_reg == CMD_RD && !err_reg) ? acc_rdata : '0;
   assign halted    = halted_reg;
   assign dbg_stall = stall_reg;
   assign bp_event  = bp_event_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         phase_reg    <= PH_SINGLE;
         op_reg       <= CMD_NOP;
         err_reg      <= 1'b0;
         fail_reg     <= 1'b0;
         stall_reg    <= HALT_ON_RESET;
         halted_reg   <= HALT_ON_RESET;
         bp_event_reg <= 1'b0;
         shadow_reg   <= '0;
         wr_data_reg  <= '0;
         wr_ctrl_reg  <= 1'b0;
         run_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         op_reg       <= op_next;
         err_reg      <= err_next;
         fail_reg     <= fail_next;
         stall_reg    <= stall_next;
         halted_reg   <= halted_next;
         bp_event_reg <= bp_event_next;
         shadow_reg   <= shadow_next;
         wr_data_reg  <= wr_data_next;
         wr_ctrl_reg  <= wr_ctrl_next;
         run_cnt_reg  <= run_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      op_next       = op_reg;
      err_next      = err_reg;
      fail_next     = fail_reg;
      stall_next    = stall_reg;
      halted_next   = halted_reg;
      bp_event_next = 1'b0;
      shadow_next   = shadow_reg;
      wr_data_next  = wr_data_reg;
      wr_ctrl_next  = wr_ctrl_reg;
      run_cnt_next  = run_cnt_reg;
      halted_eff    = halted_reg;
      acc_start     = 1'b0;
      acc_we        = 1'b0;
      acc_addr      = '0;
      acc_data      = '0;
      case (state_reg)
         S_IDLE: begin
            // Auto-halt takes effect before a coincident command is judged.
            if (!halted_reg && dbg_bp) begin
               stall_next    = 1'b1;
               halted_next   = 1'b1;
               bp_event_next = 1'b1;
               halted_eff    = 1'b1;
            end
            if (cmd_valid) begin
               op_next      = dbg_cmd_op_t'(cmd_op);
               err_next     = 1'b0;
               fail_next    = 1'b0;
               phase_next   = PH_SINGLE;
               wr_ctrl_next = (cmd_op == CMD_WR) && (cmd_addr == CTRL_ADDR);
               wr_data_next = cmd_data[1:0];
               state_next   = S_RESP;
               case (dbg_cmd_op_t'(cmd_op))
                  CMD_NOP: ;
                  CMD_HALT: begin
                     stall_next  = 1'b1;
                     halted_next = 1'b1;
                  end
                  CMD_RESUME: if (halted_eff) begin
                     acc_start  = 1'b1;
                     acc_we     = 1'b1;
                     acc_addr   = HIT_ADDR;
                     phase_next = PH_HIT;
                     state_next = S_ACC;
                  end
                  CMD_STEP: if (halted_eff) begin
                     acc_start  = 1'b1;
                     acc_we     = 1'b1;
                     acc_addr   = CTRL_ADDR;
                     acc_data   = {{(XLEN-2){1'b0}}, shadow_reg[1], 1'b1};
                     phase_next = PH_SET;
                     state_next = S_ACC;
                  end else begin
                     err_next = 1'b1;
                  end
                  CMD_RD, CMD_WR: begin
                     if (!halted_eff && addr_bank(cmd_addr) != DBG_INTERNAL) begin
                        err_next = 1'b1;
                     end else begin
                        acc_start  = 1'b1;
                        acc_we     = (cmd_op == CMD_WR);
                        acc_addr   = cmd_addr;
                        acc_data   = cmd_data;
                        state_next = S_ACC;
                     end
                  end
                  default: err_next = 1'b1;
               endcase
            end
         end
         S_ACC: if (acc_done) begin
            err_next   = err_reg | acc_err;
            fail_next  = acc_err;
            state_next = S_GAP;
            if (!acc_err && wr_ctrl_reg && op_reg == CMD_WR)
               shadow_next = wr_data_reg;
         end
         S_GAP: begin
            state_next = S_RESP;
            if (fail_reg) begin
               // A failed step access abandons the rest but leaves the core stalled.
               if (op_reg == CMD_STEP) stall_next = 1'b1;
            end else if (op_reg == CMD_RESUME) begin
               stall_next  = 1'b0;
               halted_next = 1'b0;
            end else if (op_reg == CMD_STEP && phase_reg == PH_SET) begin
               stall_next   = 1'b0;
               run_cnt_next = '0;
               state_next   = S_RUN;
            end else if (op_reg == CMD_STEP && phase_reg == PH_HIT) begin
               acc_start  = 1'b1;
               acc_we     = 1'b1;
               acc_addr   = CTRL_ADDR;
               acc_data   = {{(XLEN-2){1'b0}}, shadow_reg[1], 1'b0};
               phase_next = PH_CLR;
               state_next = S_ACC;
            end
         end
         S_RUN: begin
            run_cnt_next = run_cnt_reg + 1'b1;
            if (dbg_bp || run_cnt_reg == CW'(TIMEOUT - 1)) begin
               if (!dbg_bp) err_next = 1'b1;
               stall_next = 1'b1;
               acc_start  = 1'b1;
               acc_we     = 1'b1;
               acc_addr   = HIT_ADDR;
               phase_next = PH_HIT;
               state_next = S_ACC;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_riscv_dbg_ctrl.sv
// Directed bench for riscv_dbg_ctrl with a debug-unit model that acks the
// third strobe cycle and raises dbg_bp on request.
module tb_riscv_dbg_ctrl;
   import riscv_du_pkg::*;

   localparam int XLEN = 32;
   localparam logic [31:0] RD_VAL = 32'hDEAD_BEEF;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     cmd_valid = 1'b0;
   logic                     cmd_ready;
   logic [2:0]               cmd_op = 3'd0;
   logic [DBG_ADDR_SIZE-1:0] cmd_addr = '0;
   logic [XLEN-1:0]          cmd_data = '0;
   logic                     rsp_valid, rsp_err, halted, bp_event;
   logic [XLEN-1:0]          rsp_data;
   logic                     dbg_stall, dbg_strb, dbg_we;
   logic [DBG_ADDR_SIZE-1:0] dbg_addr;
   logic [XLEN-1:0]          dbg_dati;
   logic [XLEN-1:0]          dbg_dato = RD_VAL;
   logic                     dbg_ack = 1'b0;
   logic                     dbg_bp = 1'b0;

   int errors = 0;
   int checks = 0;

   // debug-unit model state (written only by the model process)
   int   strb_rise = 0, strb_hi = 0, bp_ev_cnt = 0, ack_cnt = 0, stall_low = 0;
   int   bp_done = 0, log_n = 0;
   logic prev_strb = 1'b0;
   logic                     log_we   [0:63];
   logic [DBG_ADDR_SIZE-1:0] log_addr [0:63];
   logic [XLEN-1:0]          log_dat  [0:63];
   // model controls (written only by the main process)
   int ack_en = 1, bp_req = 0, bp_wait = 0;

   riscv_dbg_ctrl #(.XLEN(XLEN), .TIMEOUT(16), .HALT_ON_RESET(1'b0)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .halted(halted), .bp_event(bp_event), .dbg_stall(dbg_stall),
      .dbg_strb(dbg_strb), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_dati(dbg_dati), .dbg_dato(dbg_dato), .dbg_ack(dbg_ack),
      .dbg_bp(dbg_bp)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dbg_strb && !prev_strb) strb_rise++;
      if (dbg_strb) strb_hi++;
      prev_strb = dbg_strb;
      if (bp_event) bp_ev_cnt++;
      if (dbg_ack) begin
         dbg_ack = 1'b0;
         ack_cnt = 0;
      end else if (dbg_strb) begin
         ack_cnt++;
         if (ack_en != 0 && ack_cnt == 3) begin
            dbg_ack = 1'b1;
            if (log_n < 64) begin
               log_we[log_n]   = dbg_we;
               log_addr[log_n] = dbg_addr;
               log_dat[log_n]  = dbg_dati;
               log_n++;
            end
         end
      end else begin
         ack_cnt = 0;
      end
      if (dbg_bp) begin
         dbg_bp = 1'b0;
      end else if (bp_req != bp_done) begin
         if (bp_wait == 0) begin
            dbg_bp = 1'b1;
            bp_done++;
         end else if (!dbg_stall) begin
            stall_low++;
            if (stall_low == bp_wait) begin
               dbg_bp = 1'b1;
               bp_done++;
               stall_low = 0;
            end
         end
      end
   end

   task automatic do_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] data,
                         input bit bp_with, output int lat, output logic [31:0] rdata, output logic err);
      if (bp_with) begin
         @(posedge clk);
         #1 bp_wait = 0;
         bp_req++;
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_data;
      err   = rsp_err;
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout: op=%0d no rsp_valid within %0d cycles (required a response)", op, lat);
      end
      $display("cmd op=%0d addr=%h data=%h -> lat=%0d rdata=%h err=%0b halted=%0b stall=%0b",
               op, addr, data, lat, rdata, err, halted, dbg_stall);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (dbg_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", dbg_stall); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (dbg_strb !== 1'b0) begin errors++; $display("FAIL reset_strb: got %b expected 0", dbg_strb); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (bp_event !== 1'b0) begin errors++; $display("FAIL reset_bp_event: got %b expected 0", bp_event); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_resume_running();
      int lat, s0; logic [31:0] d; logic e;
      s0 = strb_rise;
      do_cmd(CMD_RESUME, 16'h0, 32'h0, 1'b0, lat, d, e);
      checks++; if (lat !== 1) begin errors++; $display("FAIL resume_run_lat: got %0d expected 1", lat); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL resume_run_err: got %b expected 0", e); end
      checks++; if (strb_rise - s0 !== 0) begin errors++; $display("FAIL resume_run_strb: got %0d strobes expected 0", strb_rise - s0); end
   endtask

   task automatic test_rd_running_err();
      int lat, s0; logic [31:0] d; logic e;
      s0 = strb_rise;
      do_cmd(CMD_RD, 16'h1005, 32'h0, 1'b0, lat, d, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL rd_run_err: got %b expected 1", e); end
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_run_data: got %h expected 0", d); end
      checks++; if (strb_rise - s0 !== 0) begin errors++; $display("FAIL rd_run_strb: got %0d strobes expected 0", strb_rise - s0); end
   endtask

   task automatic test_wr_ctrl_running();
      int lat, l0; logic [31:0] d; logic e;
      l0 = log_n;
      do_cmd(CMD_WR, 16'h0000, 32'h2, 1'b0, lat, d, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_ctrl_err: got %b expected 0", e); end
      checks++; if (log_n - l0 !== 1) begin errors++; $display("FAIL wr_ctrl_count: got %0d accesses expected 1", log_n - l0); end
      checks++; if ({log_we[l0], log_addr[l0], log_dat[l0]} !== {1'b1, 16'h0000, 32'h2})
         begin errors++; $display("FAIL wr_ctrl_access: got we=%b addr=%h dat=%h expected we=1 addr=0000 dat=2", log_we[l0], log_addr[l0], log_dat[l0]); end
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_ctrl_rdata: got %h expected 0", d); end
   endtask

   task automatic test_halt();
      int lat; logic [31:0] d; logic e;
      do_cmd(CMD_HALT, 16'h0, 32'h0, 1'b0, lat, d, e);
      checks++; if (lat !== 1) begin errors++; $display("FAIL halt_lat: got %0d expected 1", lat); end
      checks++; if ({dbg_stall, halted} !== 2'b11) begin errors++; $display("FAIL halt_state: got stall=%b halted=%b expected 1 1", dbg_stall, halted); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL halt_err: got %b expected 0", e); end
      do_cmd(CMD_HALT, 16'h0, 32'h0, 1'b0, lat, d, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL halt_again_err: got %b expected 0", e); end
   endtask

   task automatic test_rd_halted();
      int lat, s0; logic [31:0] d; logic e;
      s0 = strb_rise;
      do_cmd(CMD_RD, 16'h1005, 32'h0, 1'b0, lat, d, e);
      checks++; if (lat !== 5) begin errors++; $display("FAIL rd_lat: got %0d expected 5", lat); end
      checks++; if (d !== RD_VAL) begin errors++; $display("FAIL rd_data: got %h expected %h", d, RD_VAL); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", e); end
      checks++; if (strb_rise - s0 !== 1) begin errors++; $display("FAIL rd_strb: got %0d strobes expected 1", strb_rise - s0); end
   endtask

   task automatic test_step();
      int lat, s0, l0, b0; logic [31:0] d; logic e;
      logic [15:0] exp_addr [0:2];
      logic [31:0] exp_dat  [0:2];
      exp_addr[0] = 16'h0000; exp_dat[0] = 32'h3;
      exp_addr[1] = 16'h0001; exp_dat[1] = 32'h0;
      exp_addr[2] = 16'h0000; exp_dat[2] = 32'h2;
      s0 = strb_rise; l0 = log_n; b0 = bp_ev_cnt;
      bp_wait = 4;
      bp_req++;
      do_cmd(CMD_STEP, 16'h0, 32'h0, 1'b0, lat, d, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL step_err: got %b expected 0", e); end
      checks++; if ({halted, dbg_stall} !== 2'b11) begin errors++; $display("FAIL step_halted: got halted=%b stall=%b expected 1 1", halted, dbg_stall); end
      checks++; if (bp_ev_cnt - b0 !== 0) begin errors++; $display("FAIL step_bp_event: got %0d pulses expected 0", bp_ev_cnt - b0); end
      checks++; if (strb_rise - s0 !== 3) begin errors++; $display("FAIL step_strb: got %0d strobes expected 3", strb_rise - s0); end
      checks++; if (log_n - l0 !== 3) begin errors++; $display("FAIL step_count: got %0d accesses expected 3", log_n - l0); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({log_we[l0+i], log_addr[l0+i], log_dat[l0+i]} !== {1'b1, exp_addr[i], exp_dat[i]}) begin
            errors++;
            $display("FAIL step_access%0d: got we=%b addr=%h dat=%h expected we=1 addr=%h dat=%h",
                     i, log_we[l0+i], log_addr[l0+i], log_dat[l0+i], exp_addr[i], exp_dat[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int lat, h0; logic [31:0] d; logic e;
      ack_en = 0;
      h0 = strb_hi;
      do_cmd(CMD_RD, 16'h1005, 32'h0, 1'b0, lat, d, e);
      checks++; if (strb_hi - h0 !== 16) begin errors++; $display("FAIL tmo_strb_len: got %0d cycles expected 16", strb_hi - h0); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", e); end
      checks++; if (lat !== 18) begin errors++; $display("FAIL tmo_lat: got %0d expected 18", lat); end
      @(negedge clk);
      checks++; if ({cmd_ready, rsp_valid, dbg_strb} !== 3'b100) begin errors++; $display("FAIL tmo_idle: got ready=%b rsp=%b strb=%b expected 1 0 0", cmd_ready, rsp_valid, dbg_strb); end
      ack_en = 1;
   endtask

   task automatic test_resume();
      int lat, l0; logic [31:0] d; logic e;
      l0 = log_n;
      do_cmd(CMD_RESUME, 16'h0, 32'h0, 1'b0, lat, d, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL resume_err: got %b expected 0", e); end
      checks++; if ({log_we[l0], log_addr[l0], log_dat[l0]} !== {1'b1, 16'h0001, 32'h0})
         begin errors++; $display("FAIL resume_access: got we=%b addr=%h dat=%h expected we=1 addr=0001 dat=0", log_we[l0], log_addr[l0], log_dat[l0]); end
      checks++; if ({dbg_stall, halted} !== 2'b00) begin errors++; $display("FAIL resume_state: got stall=%b halted=%b expected 0 0", dbg_stall, halted); end
   endtask

   task automatic test_auto_halt();
      int b0;
      b0 = bp_ev_cnt;
      @(posedge clk);
      #1 bp_wait = 0;
      bp_req++;
      repeat (4) @(negedge clk);
      $display("bp pulse -> bp_event pulses=%0d halted=%0b stall=%0b", bp_ev_cnt - b0, halted, dbg_stall);
      checks++; if (bp_ev_cnt - b0 !== 1) begin errors++; $display("FAIL auto_bp_event: got %0d pulses expected 1", bp_ev_cnt - b0); end
      checks++; if ({halted, dbg_stall} !== 2'b11) begin errors++; $display("FAIL auto_halted: got halted=%b stall=%b expected 1 1", halted, dbg_stall); end
      test_resume();
   endtask

   task automatic test_bp_coincident();
      int lat, b0; logic [31:0] d; logic e;
      b0 = bp_ev_cnt;
      do_cmd(CMD_RD, 16'h1005, 32'h0, 1'b1, lat, d, e);
      checks++; if ({e, d} !== {1'b0, RD_VAL}) begin errors++; $display("FAIL coinc_rd: got err=%b data=%h expected 0 %h", e, d, RD_VAL); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL coinc_halted: got %b expected 1", halted); end
      checks++; if (bp_ev_cnt - b0 !== 1) begin errors++; $display("FAIL coinc_bp_event: got %0d pulses expected 1", bp_ev_cnt - b0); end
   endtask

   initial begin
      test_reset();
      test_resume_running();
      test_rd_running_err();
      test_wr_ctrl_running();
      test_halt();
      test_rd_halted();
      test_step();
      test_timeout();
      test_resume();
      test_auto_halt();
      test_bp_coincident();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/riscv_dbg_ctrl.md
# riscv_dbg_ctrl

Debug command sequencer between the external debug transport (JTAG/TAP side) and the core debug unit's dbg_* port. It turns single high-level commands into correctly ordered debug-port strobe/ack transactions: halt, resume, single step, register read and register write. It also tracks the halted/running state, including automatic halts raised by breakpoints. Instantiated next to the debug unit in the core top level.

## Interface
- XLEN, 32, data width
- TIMEOUT, 1024, maximum cycles to wait for dbg_ack, or for dbg_bp during a step
- HALT_ON_RESET, 0, reset value of dbg_stall and halted

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  command opcode: NOP, HALT, RESUME, STEP, RD, WR
- cmd_addr  in  DBG_ADDR_SIZE  register address for RD/WR
- cmd_data  in  XLEN  write data for WR
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  XLEN  read data; 0 for non-RD commands
- rsp_err  out  1  command failed (timeout or illegal)
- halted  out  1  core is stalled by the debugger
- bp_event  out  1  one-cycle pulse on a breakpoint-induced halt
- dbg_stall  out  1  debug-port stall
- dbg_strb  out  1  debug-port strobe
- dbg_we  out  1  debug-port write enable
- dbg_addr  out  DBG_ADDR_SIZE  debug-port address
- dbg_dati  out  XLEN  debug-port write data
- dbg_dato  in  XLEN  debug-port read data
- dbg_ack  in  1  debug-port acknowledge, single-cycle
- dbg_bp  in  1  breakpoint/exception hit, single-cycle

## Operation
- FSM states: IDLE, ACC, GAP, RUN, RESP. A phase register selects the next micro-op for multi-step commands.
- cmd_ready is 1 only in IDLE. Commands arriving while busy are not accepted.
- Bank is cmd_addr[DBG_ADDR_SIZE-1:DU_ADDR_SIZE]. RD/WR to any bank other than DBG_INTERNAL while halted=0 produces RESP with rsp_err=1 and no strobe.
- ACC: dbg_strb=1, with dbg_addr, dbg_we and dbg_dati stable. Held until dbg_ack. On the ack cycle, dbg_dato is captured for RD. Then go to GAP.
- GAP: dbg_strb=0 for exactly one cycle, so the debug unit sees a fresh strobe edge on the next access.
- HALT: dbg_stall←1, halted←1, then RESP. Issued while already halted: still a legal RESP with rsp_err=0.
- RESUME:
  - ACC write DBG_HIT=0, clearing the sticky hits.
  - GAP.
  - dbg_stall←0, halted←0.
  - RESP.
  - Issued while running: immediate RESP with rsp_err=0.
- STEP requires halted=1; otherwise RESP with rsp_err=1. Sequence:
  - ACC write DBG_CTRL={ctrl_shadow[1],1}.
  - GAP.
  - RUN: dbg_stall=0, wait for dbg_bp.
  - dbg_stall←1.
  - ACC write DBG_HIT=0.
  - GAP.
  - ACC write DBG_CTRL={ctrl_shadow[1],0}.
  - GAP.
  - RESP.
- ctrl_shadow[1:0] is updated by every successful WR to DBG_CTRL in the internal bank.
- Auto-halt: in IDLE with halted=0, dbg_bp=1 causes dbg_stall←1, halted←1 and bp_event=1 on the next cycle. The dbg_bp consumed in RUN does not pulse bp_event.
- Timeout: a 10-bit-or-wider counter is cleared on entry to ACC or RUN.
  - Reaching TIMEOUT in ACC: drop strobe, go to GAP, then RESP with rsp_err=1. Any remaining STEP micro-ops are skipped, except that dbg_stall is forced to 1.
  - Reaching TIMEOUT in RUN: dbg_stall←1, then continue with the restore writes; the final RESP has rsp_err=1.

## Timing
- Reset values (rst=1 at a clk edge):
  - dbg_stall=halted=HALT_ON_RESET.
  - All other outputs 0; FSM to IDLE; ctrl_shadow=0.
  - Reset mid-transaction abandons it. No response is issued.
- dbg_strb rises the cycle after acceptance.
- RD latency = ack latency + 2 cycles (GAP, RESP). With the debug unit's 3-cycle ack, rsp_valid is 5 cycles after acceptance.
- rsp_valid lasts exactly one cycle. rsp_data/rsp_err are valid only while rsp_valid=1.
- The cycle after RESP is IDLE, with cmd_ready=1.
- dbg_bp coincident with command acceptance: the auto-halt wins, then the command executes with halted=1.

## Structure
- Add to riscv_du_pkg: the dbg_cmd_op enum (NOP=0, HALT=1, RESUME=2, STEP=3, RD=4, WR=5). Reuse the existing DBG_INTERNAL, DBG_CTRL, DBG_HIT, DU_ADDR_SIZE and DBG_ADDR_SIZE constants.
- Sub-module riscv_dbg_acc holds the strobe/ack/GAP/timeout access engine.
  - Inputs: start, we, addr, data.
  - Outputs: done, err, rdata.
- The FSM in riscv_dbg_ctrl sequences riscv_dbg_acc.

## Test plan
- Reset with HALT_ON_RESET=0, then HALT → next cycle dbg_stall=1, halted=1; rsp_valid with rsp_err=0.
- Halted, RD of the GPRS bank with an ack model delaying 3 cycles returning 0xDEADBEEF → one strobe; rsp_data=0xDEADBEEF, 5 cycles after acceptance.
- Running, RD of the GPRS bank → rsp_err=1, dbg_strb never asserted. Running, WR DBG_CTRL=2 → succeeds, ctrl_shadow=2.
- Halted, STEP with dbg_bp 4 cycles after stall release → writes CTRL=0x3, HIT=0, CTRL=0x2 in order, each separated by a strobe-low cycle; halted=1, rsp_err=0, no bp_event.
- Ack never returned, TIMEOUT=16 → strobe drops after 16 cycles; rsp_err=1; FSM back in IDLE.
- Running with a dbg_bp pulse → bp_event one cycle, halted=1; a following RESUME writes HIT=0, then dbg_stall=0.
